// File: rtl/stack_cmd_ctrl.sv
// stack_cmd_ctrl
//   Command-level master for a registered-output LIFO. Converts one CPU-side
//   stack command (PUSH, POP, SWAP, DUP) into a timed sequence of push/pop
//   strobes and returns a one-cycle done/err/rsp_data response.
//   Legality (overflow/underflow) is decided from lifo_count at the accept
//   edge; an illegal command produces no strobes.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd_op              : 00 PUSH, 01 POP, 10 SWAP, 11 DUP
//   cmd_data            : PUSH operand
//   done/err/rsp_data   : one-cycle completion response
//   lifo_push/lifo_pop  : strobes to the LIFO (never both high)
//   lifo_data           : write data to the LIFO
//   lifo_q              : LIFO read data, valid the cycle after a pop strobe
//   lifo_empty/full     : LIFO flags (not used by the controller)
//   lifo_count          : LIFO occupancy, 0..DEPTH
module stack_cmd_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [WIDTH-1:0] lifo_data,
  input  logic [WIDTH-1:0] lifo_q,
  input  logic             lifo_empty,
  input  logic             lifo_full,
  input  logic [CW-1:0]    lifo_count
);

  typedef enum logic [3:0] {
    IDLE, ERR, PUSH1, POP1, POP2, SW1, SW2, SW3, SW4, DP1, DP2, DP3, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_SWAP = 2'b10,
    OP_DUP  = 2'b11
  } op_t;

  state_t           r_state;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_lifo_push;
  logic             r_lifo_pop;
  logic [WIDTH-1:0] r_lifo_data;
  logic [WIDTH-1:0] r_tmp_a;
  logic             r_dup_bypass;
  logic             w_illegal;
  logic             w_unused_flags;

  // Flags are carried for interface compatibility only; legality uses the count.
  assign w_unused_flags = lifo_empty ^ lifo_full;

  assign cmd_ready = (r_state == IDLE) && !reset;
  assign done      = r_done;
  assign err       = r_err;
  assign rsp_data  = r_rsp_data;
  assign lifo_push = r_lifo_push;
  assign lifo_pop  = r_lifo_pop;
  // DUP pushes A in the very cycle A first appears on lifo_q, so the first
  // DUP push forwards lifo_q; every other push uses the registered data.
  assign lifo_data = r_dup_bypass ? lifo_q : r_lifo_data;

  always_comb begin
    w_illegal = 1'b0;
    case (cmd_op)
      OP_PUSH: w_illegal = (lifo_count == CW'(DEPTH));
      OP_POP:  w_illegal = (lifo_count == '0);
      OP_SWAP: w_illegal = (lifo_count < CW'(2));
      OP_DUP:  w_illegal = (lifo_count == '0) || (lifo_count == CW'(DEPTH));
      default: w_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_data   <= '0;
      r_lifo_push  <= 1'b0;
      r_lifo_pop   <= 1'b0;
      r_lifo_data  <= '0;
      r_tmp_a      <= '0;
      r_dup_bypass <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (w_illegal) begin
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_rsp_data <= '0;
              r_state    <= ERR;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  r_lifo_push <= 1'b1;
                  r_lifo_data <= cmd_data;
                  r_tmp_a     <= cmd_data;
                  r_state     <= PUSH1;
                end
                OP_POP: begin
                  r_lifo_pop <= 1'b1;
                  r_state    <= POP1;
                end
                OP_SWAP: begin
                  r_lifo_pop <= 1'b1;
                  r_state    <= SW1;
                end
                default: begin
                  r_lifo_pop <= 1'b1;
                  r_state    <= DP1;
                end
              endcase
            end
          end
        end
        ERR: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        PUSH1: begin
          r_lifo_push <= 1'b0;
          r_done      <= 1'b1;
          r_err       <= 1'b0;
          r_rsp_data  <= r_tmp_a;
          r_state     <= DONE;
        end
        POP1: begin
          r_lifo_pop <= 1'b0;
          r_state    <= POP2;
        end
        POP2: begin
          // Popped value goes straight to the response; tmp_a keeps a copy.
          r_tmp_a    <= lifo_q;
          r_done     <= 1'b1;
          r_err      <= 1'b0;
          r_rsp_data <= lifo_q;
          r_state    <= DONE;
        end
        SW1: begin
          // Second pop strobe: lifo_pop stays high.
          r_state <= SW2;
        end
        SW2: begin
          r_lifo_pop  <= 1'b0;
          r_tmp_a     <= lifo_q;
          r_lifo_data <= lifo_q;
          r_lifo_push <= 1'b1;
          r_state     <= SW3;
        end
        SW3: begin
          // B is pushed straight from lifo_q; no separate holding register.
          r_lifo_data <= lifo_q;
          r_state     <= SW4;
        end
        SW4: begin
          r_lifo_push <= 1'b0;
          r_done      <= 1'b1;
          r_err       <= 1'b0;
          r_rsp_data  <= r_tmp_a;
          r_state     <= DONE;
        end
        DP1: begin
          r_lifo_pop   <= 1'b0;
          r_lifo_push  <= 1'b1;
          r_dup_bypass <= 1'b1;
          r_state      <= DP2;
        end
        DP2: begin
          r_tmp_a      <= lifo_q;
          r_lifo_data  <= lifo_q;
          r_dup_bypass <= 1'b0;
          r_state      <= DP3;
        end
        DP3: begin
          r_lifo_push <= 1'b0;
          r_done      <= 1'b1;
          r_err       <= 1'b0;
          r_rsp_data  <= r_tmp_a;
          r_state     <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
